// File: rtl/conv2_sink_pkg.sv
// Shared types and sizing for the conv2 feature-map sink.
// Frame geometry, address width and the control state encoding.
package conv2_sink_pkg;

    localparam int WIDTH        = 11;
    localparam int HEIGHT       = 11;
    localparam int CHANNELS     = 16;
    localparam int FRAME_PIXELS = WIDTH * HEIGHT;
    localparam int ADDR_W       = $clog2(FRAME_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READY
    } state_t;

endpackage

// File: rtl/fmap_ram.sv
// Frame buffer: one synchronous write port, one registered read port.
// Reads of an index being written return the old word.
module fmap_ram
    import conv2_sink_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [CHANNELS-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CHANNELS-1:0] rd_data
);

    logic [CHANNELS-1:0] mem [FRAME_PIXELS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-frame addresses read as zero instead of aliasing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_addr < ADDR_W'(FRAME_PIXELS)) begin
                rd_data <= mem[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/conv2_fmap_sink.sv
// Captures one 11x11x16 conv2 output frame and holds it for readout
// until the downstream layer releases it.
module conv2_fmap_sink
    import conv2_sink_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [CHANNELS-1:0] conv2_in,
    input  logic                frame_release,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CHANNELS-1:0] rd_data,
    output logic                rd_valid,
    output logic                frame_ready,
    output logic                frame_done,
    output logic [ADDR_W-1:0]   pix_count,
    output logic                overflow
);

    state_t state, state_next;
    logic   wr_en;
    logic   last_pix;

    assign last_pix    = (pix_count == ADDR_W'(FRAME_PIXELS - 1));
    assign frame_ready = (state == READY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        unique case (state)
            IDLE, CAPTURE: begin
                if (valid_in) begin
                    wr_en      = 1'b1;
                    state_next = last_pix ? READY : CAPTURE;
                end
            end
            READY: begin
                if (frame_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pixel arriving while a frame is held is lost; flag it until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_count  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            frame_done <= wr_en && last_pix;
            rd_valid   <= rd_en;
            if (wr_en) begin
                pix_count <= pix_count + ADDR_W'(1);
            end else if (state == READY && frame_release) begin
                pix_count <= '0;
            end
            if (state == READY && valid_in) begin
                overflow <= 1'b1;
            end
        end
    end

    fmap_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (pix_count),
        .wr_data (conv2_in),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_conv2_fmap_sink.sv
// Directed bench for conv2_fmap_sink: capture, hold, overflow,
// release, mid-frame reset and the read port corner cases.
module tb_conv2_fmap_sink;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [15:0] conv2_in;
    logic        frame_release;
    logic        rd_en;
    logic [6:0]  rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        frame_ready;
    logic        frame_done;
    logic [6:0]  pix_count;
    logic        overflow;

    int tests;
    int fails;

    conv2_fmap_sink dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .conv2_in      (conv2_in),
        .frame_release (frame_release),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .frame_ready   (frame_ready),
        .frame_done    (frame_done),
        .pix_count     (pix_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus primitives: called at a negedge, return at the next one.
    task automatic push(input logic [15:0] d);
        valid_in = 1'b1;
        conv2_in = d;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [6:0] a, output logic [15:0] d,
                      output logic v);
        rd_en   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_en   = 1'b0;
        d       = rd_data;
        v       = rd_valid;
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        tests++;
        if ({frame_ready, frame_done, overflow, rd_valid} !== 4'b0 ||
            pix_count !== 7'd0 || rd_data !== 16'h0) begin
            fails++;
            $display("FAIL reset: rdy=%b done=%b ovf=%b rv=%b cnt=%0d rd=%h want all 0",
                     frame_ready, frame_done, overflow, rd_valid, pix_count, rd_data);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_full_frame();
        logic [15:0] d;
        logic        v;
        int          early;
        early = 0;
        for (int i = 0; i < 121; i++) begin
            push(16'(i) ^ 16'hA5A5);
            if (i < 120 && (frame_done || frame_ready)) early++;
        end
        tests++;
        if (early != 0) begin
            fails++;
            $display("FAIL full_early_done: %0d early cycles, want 0", early);
        end
        tests++;
        if (frame_done !== 1'b1 || frame_ready !== 1'b1 || pix_count !== 7'd121) begin
            fails++;
            $display("FAIL full_done: done=%b rdy=%b cnt=%0d want 1 1 121",
                     frame_done, frame_ready, pix_count);
        end
        idle(1);
        tests++;
        if (frame_done !== 1'b0 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL full_pulse: done=%b rdy=%b want 0 1", frame_done, frame_ready);
        end
        rd(7'd0, d, v);
        tests++;
        if (d !== 16'hA5A5 || v !== 1'b1) begin
            fails++;
            $display("FAIL full_rd0: got %h v=%b want a5a5 v=1", d, v);
        end
        rd(7'd60, d, v);
        tests++;
        if (d !== 16'hA599 || v !== 1'b1) begin
            fails++;
            $display("FAIL full_rd60: got %h v=%b want a599 v=1", d, v);
        end
        rd(7'd120, d, v);
        tests++;
        if (d !== 16'hA5DD || v !== 1'b1) begin
            fails++;
            $display("FAIL full_rd120: got %h v=%b want a5dd v=1", d, v);
        end
        idle(1);
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rd_valid_idle: got %b want 0", rd_valid);
        end
    endtask

    task automatic test_gapped();
        logic [15:0] d;
        logic        v;
        int          early;
        int          bad;
        release_frame();
        early = 0;
        for (int i = 0; i < 121; i++) begin
            push(16'(i) ^ 16'hA5A5);
            if (i < 120 && frame_done) early++;
            if (i < 120) begin
                idle(2);
                if (frame_done || frame_ready) early++;
            end
        end
        tests++;
        if (early != 0 || frame_done !== 1'b1 || pix_count !== 7'd121) begin
            fails++;
            $display("FAIL gap_done: early=%0d done=%b cnt=%0d want 0 1 121",
                     early, frame_done, pix_count);
        end
        bad = 0;
        for (int i = 0; i < 121; i++) begin
            rd(7'(i), d, v);
            if (d !== (16'(i) ^ 16'hA5A5) || v !== 1'b1) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL gap_contents: %0d bad words, want 0", bad);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic        v;
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_pre: got %b want 0", overflow);
        end
        push(16'h1234);
        idle(1);
        push(16'h5678);
        tests++;
        if (overflow !== 1'b1 || pix_count !== 7'd121 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: ovf=%b cnt=%0d rdy=%b want 1 121 1",
                     overflow, pix_count, frame_ready);
        end
        rd(7'd0, d, v);
        tests++;
        if (d !== 16'hA5A5) begin
            fails++;
            $display("FAIL ovf_mem0: got %h want a5a5", d);
        end
    endtask

    task automatic test_release_new_frame();
        logic [15:0] d;
        logic        v;
        int          bad;
        release_frame();
        tests++;
        if (frame_ready !== 1'b0 || pix_count !== 7'd0) begin
            fails++;
            $display("FAIL rel_state: rdy=%b cnt=%0d want 0 0", frame_ready, pix_count);
        end
        for (int i = 0; i < 121; i++) push(16'hFFFF);
        tests++;
        if (frame_done !== 1'b1 || frame_ready !== 1'b1) begin
            fails++;
            $display("FAIL rel_done: done=%b rdy=%b want 1 1", frame_done, frame_ready);
        end
        bad = 0;
        for (int i = 0; i < 121; i++) begin
            rd(7'(i), d, v);
            if (d !== 16'hFFFF) bad++;
        end
        tests++;
        if (bad != 0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL rel_contents: bad=%0d ovf=%b want 0 1", bad, overflow);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] d;
        logic        v;
        int          early;
        int          bad;
        release_frame();
        for (int i = 0; i < 50; i++) push(16'h0F0F);
        tests++;
        if (pix_count !== 7'd50) begin
            fails++;
            $display("FAIL mid_count: got %0d want 50", pix_count);
        end
        rst = 1'b1;
        idle(1);
        tests++;
        if (pix_count !== 7'd0 || frame_ready !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: cnt=%0d rdy=%b ovf=%b want 0 0 0",
                     pix_count, frame_ready, overflow);
        end
        rst = 1'b0;
        idle(1);
        early = 0;
        for (int i = 0; i < 121; i++) begin
            push(16'h5000 + 16'(i));
            if (i < 120 && frame_done) early++;
        end
        tests++;
        if (early != 0 || frame_done !== 1'b1) begin
            fails++;
            $display("FAIL mid_done: early=%0d done=%b want 0 1", early, frame_done);
        end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            rd(7'(i), d, v);
            if (d !== 16'h5000 + 16'(i)) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_overwrite: %0d stale words, want 0", bad);
        end
    endtask

    task automatic test_edges();
        logic [15:0] d;
        logic        v;
        valid_in      = 1'b1;
        conv2_in      = 16'hDEAD;
        frame_release = 1'b1;
        @(negedge clk);
        valid_in      = 1'b0;
        frame_release = 1'b0;
        tests++;
        if (frame_ready !== 1'b0 || pix_count !== 7'd0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL rel_and_valid: rdy=%b cnt=%0d ovf=%b want 0 0 1",
                     frame_ready, pix_count, overflow);
        end
        release_frame();
        tests++;
        if (frame_ready !== 1'b0 || pix_count !== 7'd0) begin
            fails++;
            $display("FAIL idle_release: rdy=%b cnt=%0d want 0 0", frame_ready, pix_count);
        end
        rd(7'd121, d, v);
        tests++;
        if (d !== 16'h0 || v !== 1'b1) begin
            fails++;
            $display("FAIL rd121: got %h v=%b want 0000 v=1", d, v);
        end
        rd(7'd127, d, v);
        tests++;
        if (d !== 16'h0 || v !== 1'b1) begin
            fails++;
            $display("FAIL rd127: got %h v=%b want 0000 v=1", d, v);
        end
        push(16'hBEEF);
        tests++;
        if (pix_count !== 7'd1) begin
            fails++;
            $display("FAIL next_frame_start: cnt=%0d want 1", pix_count);
        end
        valid_in = 1'b1;
        conv2_in = 16'hCAFE;
        rd_en    = 1'b1;
        rd_addr  = 7'd1;
        @(negedge clk);
        valid_in = 1'b0;
        rd_en    = 1'b0;
        tests++;
        if (rd_data !== 16'h5001) begin
            fails++;
            $display("FAIL rbw_old: got %h want 5001", rd_data);
        end
        rd(7'd1, d, v);
        tests++;
        if (d !== 16'hCAFE) begin
            fails++;
            $display("FAIL rbw_new: got %h want cafe", d);
        end
        rd(7'd0, d, v);
        tests++;
        if (d !== 16'hBEEF) begin
            fails++;
            $display("FAIL drop_mem0: got %h want beef", d);
        end
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst           = 1'b1;
        valid_in      = 1'b0;
        conv2_in      = '0;
        frame_release = 1'b0;
        rd_en         = 1'b0;
        rd_addr       = '0;
        @(negedge clk);
        test_reset();
        test_full_frame();
        test_gapped();
        test_overflow();
        test_release_new_frame();
        test_reset_mid();
        test_edges();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv2_fmap_sink.md
Name: conv2_fmap_sink

Overview:
Receiving end of the conv layer 2 output stream. Captures the per-cycle 16-channel 1-bit pixel stream, qualified by its valid strobe, into an 11x11 feature-map frame buffer in raster order. Holds the completed frame for random-access readout by the downstream layer (pool2 / FC) until that layer releases it. Flags any pixels that arrive while a frame is being held.

Parameters:
WIDTH, 11, pixels per row of the conv2 output map (13-3+1)
HEIGHT, 11, rows per frame
CHANNELS, 16, bits per pixel (one per conv2 output channel)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
valid_in  in  1  conv2 output valid strobe; one pixel per high cycle
conv2_in  in  CHANNELS  conv2 outputs, bit k = channel k+1
frame_release  in  1  downstream is done with held frame; honoured only in READY
rd_en  in  1  read request
rd_addr  in  ADDR_W  raster pixel index (row*WIDTH+col); ADDR_W = clog2(WIDTH*HEIGHT) = 7
rd_data  out  CHANNELS  registered read data
rd_valid  out  1  rd_data valid, 1 cycle after rd_en
frame_ready  out  1  complete frame held (state READY)
frame_done  out  1  single-cycle pulse when frame completes
pix_count  out  ADDR_W  pixels captured in current frame
overflow  out  1  sticky: a valid pixel was dropped

Behaviour:
- Reset (async, active-high): state IDLE, pix_count=0, rd_data=0, rd_valid=0, frame_ready=0, frame_done=0, overflow=0. Buffer contents are not cleared.
- FRAME = WIDTH*HEIGHT = 121 pixels.
- IDLE: pix_count=0. valid_in writes conv2_in to mem[0], pix_count becomes 1, state goes to CAPTURE.
- CAPTURE: each valid_in writes mem[pix_count] and increments pix_count. Gaps in valid_in are allowed and keep state unchanged.
- Frame completion: a write at index FRAME-1 moves state to READY on the next edge. In that same cycle frame_done=1 for exactly one cycle and frame_ready=1. pix_count holds at FRAME.
- READY: frame_ready=1. valid_in is dropped (no write) and overflow is set; overflow stays set until reset.
- Release: frame_release in READY moves state to IDLE on the next edge, with frame_ready=0 and pix_count=0. frame_release outside READY is ignored.
- Release and valid_in in the same cycle in READY: the pixel is dropped and overflow is set. The next frame starts with the next valid_in.
- Read port: rd_en samples rd_addr. On the next cycle rd_valid=1 and rd_data=mem[rd_addr]; if rd_addr >= FRAME, rd_data is 0.
- Reads are legal in any state. Contents are guaranteed frame-consistent only while frame_ready=1.
- Read and write to the same index in the same cycle returns the old data (read-before-write).
- Reset mid-capture discards the partial frame: state IDLE, pix_count=0.
- No backpressure on the conv2 side; the upstream stream cannot be stalled.

Decomposition:
- Package conv2_sink_pkg holds:
  - state enum: IDLE, CAPTURE, READY
  - FRAME_PIXELS constant
  - ADDR_W derivation
- Sub-module fmap_ram: FRAME x CHANNELS memory with one synchronous write port and one registered read port, read-before-write. The control FSM and counters live in the top module.

Test Plan:
1. Reset, then 121 consecutive valid_in with conv2_in = i ^ 16'hA5A5 -> frame_done pulses for 1 cycle after the 121st pixel; frame_ready=1; pix_count=121; reading addr 0/60/120 gives 16'hA5A5 / 16'hA599 / 16'hA5DD one cycle later with rd_valid=1.
2. Same frame with valid_in high every 3rd cycle -> identical buffer contents; frame_done fires only after the 121st valid.
3. Frame held, 2 extra valid_in pulses -> overflow=1; mem[0] unchanged; pix_count stays 121.
4. frame_release, then a new frame of all 16'hFFFF -> frame_ready drops the next cycle; second frame_done follows; all reads return 16'hFFFF; overflow stays 1 from case 3.
5. rst asserted after 50 pixels, then a fresh 121-pixel frame -> frame_done occurs only after 121 post-reset pixels; the old partial frame is overwritten.
6. rd_en with rd_addr=121 and rd_addr=127 -> rd_data=0, rd_valid=1; frame_release while IDLE -> no state change.
